// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One radix-2 step per clock: 32 CALC cycles plus one FIX cycle per operation.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wd_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               isDiv_q, negQ_q, negR_q, divZero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;

  logic               signedOp, aNeg, bNeg;
  logic [WIDTH-1:0]   aMag, bMag;
  logic [WIDTH:0]     mulSum, divShift;
  logic [WIDTH+1:0]   divDiff;
  logic [2*WIDTH-1:0] step_d, prodFix;
  logic [WIDTH-1:0]   quo, rem, hi_d, lo_d;

  always_comb begin
    signedOp = ~op_i[0];
    aNeg     = signedOp & a_i[WIDTH-1];
    bNeg     = signedOp & b_i[WIDTH-1];
    aMag     = aNeg ? -a_i : a_i;
    bMag     = bNeg ? -b_i : b_i;
  end

  // acc_q holds {partial product upper, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divDiff  = {1'b0, divShift} - {2'b00, opnd_q};
    step_d   = {mulSum, acc_q[WIDTH-1:1]};
    if (isDiv_q) begin
      if (divDiff[WIDTH+1])
        step_d = {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else
        step_d = {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    prodFix = negQ_q ? -acc_q : acc_q;
    quo     = acc_q[WIDTH-1:0];
    rem     = acc_q[2*WIDTH-1:WIDTH];
    hi_d    = prodFix[2*WIDTH-1:WIDTH];
    lo_d    = prodFix[WIDTH-1:0];
    if (isDiv_q) begin
      // A zero divisor leaves the dividend as remainder; re-signing restores a_i
      hi_d = negR_q ? -rem : rem;
      lo_d = divZero_q ? '1 : (negQ_q ? -quo : quo);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      isDiv_q   <= 1'b0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we_i) hi_q <= wd_i;
          if (lo_we_i) lo_q <= wd_i;
          if (start_i) begin
            isDiv_q   <= op_i[1];
            negQ_q    <= aNeg ^ bNeg;
            negR_q    <= aNeg;
            divZero_q <= (b_i == '0);
            acc_q     <= op_i[1] ? {{WIDTH{1'b0}}, aMag} : {{WIDTH{1'b0}}, bMag};
            opnd_q    <= op_i[1] ? bMag : aMag;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= CALC;
          end
        end
        CALC: begin
          acc_q <= step_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == {CNT_W{1'b1}}) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
